// File: rtl/apb_cmd_pkg.sv
// ----------------------------------------------------------------------------
// apb_cmd_pkg
// Shared types for the APB command initiator (apb_cmd_master).
//   - FSM state encoding (IDLE / SETUP / ACCESS) as fixed 2-bit constants so
//     the encoding stays stable for older tools and waveform decoders.
//   - cmd_t : queued command {write, addr, wdata} at the default bus widths.
//   - rsp_t : returned response {rdata, err, timeout} at the default bus widths.
// The top module rebuilds the same record shapes at its own parameter widths.
// The command FIFO uses cmd_t as its default item type.
// ----------------------------------------------------------------------------
package apb_cmd_pkg;

    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [CMD_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// ----------------------------------------------------------------------------
// apb_cmd_fifo
// Synchronous FIFO holding queued APB commands.
// Parameters:
//   item_t : stored record type (default apb_cmd_pkg::cmd_t)
//   DEPTH  : number of entries, power of two, >= 2
// Ports:
//   clk   in  clock
//   reset in  asynchronous active-high reset; clears the FIFO to empty
//   push  in  write din; ignored when full (even if pop is high)
//   din   in  entry to store
//   pop   in  drop the head entry; ignored when empty
//   dout  out current head entry (valid when !empty)
//   full  out no free entry
//   empty out no stored entry
// ----------------------------------------------------------------------------
module apb_cmd_fifo
    import apb_cmd_pkg::*;
#(
    parameter type         item_t = cmd_t,
    parameter int unsigned DEPTH  = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  item_t din,
    input  logic  pop,
    output item_t dout,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    item_t            mem_r [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Entry storage: write the slot addressed by the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
        end
    end

    // Pointer update for accepted pushes and pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
// APB initiator: takes read/write commands on a valid/ready stream, queues them
// in apb_cmd_fifo, runs one APB transfer at a time (SETUP, ACCESS with PREADY
// wait states, PSLVERR) and returns one response per command on a valid/ready
// stream. The response slot holds a single entry; a new transfer only starts
// when that slot is free or being drained in the same cycle.
//
// Build option: define APB_CMD_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT cycles of PREADY=0 (response err=1, timeout=1, rdata=0). Without
// it ACCESS waits indefinitely and rsp_timeout stays 0.
//
// Ports:
//   clk, reset                    clock (also PCLK), async active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/cmd_addr/cmd_wdata  command payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err/rsp_timeout response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB requester outputs (registered)
//   PRDATA/PREADY/PSLVERR              APB completer inputs
// ----------------------------------------------------------------------------
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // Same record shape as apb_cmd_pkg::cmd_t, at this instance's widths.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_item_t;

    cmd_item_t         push_item_s;
    cmd_item_t         head_item_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              start_s;
    logic              complete_s;
    logic              abort_s;

    state_t            state_r;
    logic              run_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              rsp_timeout_r;

    // cmd_ready stays low while reset is held and rises on the first clock after release.
    assign cmd_ready   = run_r && !fifo_full_s;
    assign push_s      = cmd_valid && cmd_ready;
    assign push_item_s = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    // Start needs a queued command and a response slot that is empty or draining now.
    assign start_s    = (state_r == ST_IDLE) && !fifo_empty_s && (!rsp_valid_r || rsp_ready);
    assign complete_s = (state_r == ST_ACCESS) && PREADY;

    apb_cmd_fifo #(
        .item_t (cmd_item_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (push_item_s),
        .pop   (start_s),
        .dout  (head_item_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef APB_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // PREADY=1 in the limit cycle takes priority, so abort only when PREADY is low.
    assign abort_s = (state_r == ST_ACCESS) && !PREADY &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles with PREADY low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_SETUP) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == ST_ACCESS) && !PREADY && !abort_s) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    assign abort_s = 1'b0;
`endif

    // Release flag: enables cmd_ready one clock after reset deasserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Transfer FSM and the registered APB outputs it drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Address/control/data keep their last values while idle.
                    if (start_s) begin
                        state_r   <= ST_SETUP;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        pwrite_r  <= head_item_s.write;
                        paddr_r   <= head_item_s.addr;
                        pwdata_r  <= head_item_s.wdata;
                    end
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_r <= 1'b1;
                end
                ST_ACCESS: begin
                    if (complete_s || abort_s) begin
                        state_r   <= ST_IDLE;
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry response slot: loaded at transfer end, cleared when consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (complete_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= (!pwrite_r && !PSLVERR) ? PRDATA : '0;
            rsp_err_r     <= PSLVERR;
            rsp_timeout_r <= 1'b0;
        end else if (abort_s) begin
            rsp_valid_r   <= 1'b1;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_r   <= 1'b0;
        end
    end

    assign PSEL        = psel_r;
    assign PENABLE     = penable_r;
    assign PWRITE      = pwrite_r;
    assign PADDR       = paddr_r;
    assign PWDATA      = pwdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ----------------------------------------------------------------------------
// tb_apb_cmd_master
// Directed bench for apb_cmd_master against a behavioural operand/control/
// result register slave: 0x0 operand A, 0x4 operand B, 0x8 control
// (1=AND, 2=OR, 3=XOR), 0xC result (read-only); addresses >= 0x10 answer
// with PSLVERR. PREADY is delayed by wait_states ACCESS cycles, or held low
// while stuck is set.
// ----------------------------------------------------------------------------
module tb_apb_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // ---------------- register slave model ----------------
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic [31:0] ctrl = 32'h0;
    int          acc_cnt = 0;
    int          wait_states = 0;
    logic        stuck = 1'b0;
    logic        oob;
    logic [31:0] result;

    always_comb begin
        case (ctrl[1:0])
            2'd1:    result = op_a & op_b;
            2'd2:    result = op_a | op_b;
            2'd3:    result = op_a ^ op_b;
            default: result = 32'h0;
        endcase
        oob     = (PADDR >= 32'h10);
        PSLVERR = oob;
        PREADY  = !stuck && (acc_cnt >= wait_states);
        if (oob) begin
            PRDATA = 32'hDEADBEEF;
        end else begin
            case (PADDR[3:2])
                2'd0:    PRDATA = op_a;
                2'd1:    PRDATA = op_b;
                2'd2:    PRDATA = ctrl;
                default: PRDATA = result;
            endcase
        end
    end

    always @(posedge clk) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE && !oob) begin
            case (PADDR[3:2])
                2'd0:    op_a <= PWDATA;
                2'd1:    op_b <= PWDATA;
                2'd2:    ctrl <= PWDATA;
                default: ;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Starts and ends on a negedge; returns just after the accepting edge.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 60) begin
            @(negedge clk); n++;
        end
        if (n >= 60) chk("cmd_accept_timeout", 32'd0, 32'd1);
        else @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] rd, output logic er, output logic tm);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 100) begin
            @(negedge clk); n++;
        end
        if (n >= 100) chk("rsp_wait_timeout", 32'd0, 32'd1);
        rd = rsp_rdata; er = rsp_err; tm = rsp_timeout;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [13];
    vec_t        burst [5];
    logic [31:0] rd;
    logic        er;
    logic        tm;
    int          n;
    int          en_cnt;
    int          psel_seen;

    initial begin
        vecs[0]  = '{1'b1, 32'h0,        32'hAAAAAAAA, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h4,        32'h0F0F0F0F, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h0,        32'h0,        32'hAAAAAAAA, 1'b0};
        vecs[3]  = '{1'b0, 32'h4,        32'h0,        32'h0F0F0F0F, 1'b0};
        vecs[4]  = '{1'b1, 32'h8,        32'h1,        32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'hC,        32'h0,        32'h0A0A0A0A, 1'b0};
        vecs[6]  = '{1'b1, 32'h8,        32'h2,        32'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'hC,        32'h0,        32'hAFAFAFAF, 1'b0};
        vecs[8]  = '{1'b1, 32'h8,        32'h3,        32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'hC,        32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFFC, 32'h12345678, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h10000000, 32'h0,        32'h0,        1'b1};
        vecs[12] = '{1'b0, 32'h8,        32'h0,        32'h3,        1'b0};

        burst[0] = '{1'b1, 32'h0,  32'h11111111, 32'h0,        1'b0};
        burst[1] = '{1'b0, 32'h0,  32'h0,        32'h11111111, 1'b0};
        burst[2] = '{1'b1, 32'h4,  32'h22222222, 32'h0,        1'b0};
        burst[3] = '{1'b0, 32'h4,  32'h0,        32'h22222222, 1'b0};
        burst[4] = '{1'b0, 32'h20, 32'h0,        32'h0,        1'b1};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_psel", {31'b0, PSEL}, 32'd0);
        chk("rst_penable", {31'b0, PENABLE}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // Latency: PSEL at E1, PENABLE at E2, rsp_valid at E3
        send_cmd(1'b0, 32'h0, 32'h0);
        chk("lat_e0_psel", {31'b0, PSEL}, 32'd0);
        @(negedge clk);
        chk("lat_e1_psel", {31'b0, PSEL}, 32'd1);
        chk("lat_e1_penable", {31'b0, PENABLE}, 32'd0);
        @(negedge clk);
        chk("lat_e2_penable", {31'b0, PENABLE}, 32'd1);
        @(negedge clk);
        chk("lat_e3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("lat_e3_psel", {31'b0, PSEL}, 32'd0);
        get_rsp(rd, er, tm);
        chk("lat_rdata", rd, 32'h0);

        // Table-driven transfers
        for (int i = 0; i < 13; i++) begin
            send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            get_rsp(rd, er, tm);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_timeout", i), {31'b0, tm}, 32'd0);
        end

        // Wait states: 3 cycles of PREADY low
        wait_states = 3;
        send_cmd(1'b1, 32'h4, 32'h0F0F0F0F);
        n = 0; en_cnt = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk); n++;
            if (PENABLE) begin
                en_cnt++;
                chk("ws_paddr_stable", PADDR, 32'h4);
                chk("ws_pwdata_stable", PWDATA, 32'h0F0F0F0F);
                chk("ws_pwrite_stable", {31'b0, PWRITE}, 32'd1);
            end
        end
        chk("ws_penable_cycles", en_cnt, 32'd4);
        chk("ws_rsp_latency", n, 32'd6);
        wait_states = 0;
        get_rsp(rd, er, tm);
        chk("ws_err", {31'b0, er}, 32'd0);

        // Back-pressure: response held, FIFO fills, 6th command refused
        for (int i = 0; i < 5; i++) send_cmd(burst[i].wr, burst[i].addr, burst[i].wdata);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("bp_cmd_ready_full", {31'b0, cmd_ready}, 32'd0);
        chk("bp_rsp_pending", {31'b0, rsp_valid}, 32'd1);
        chk("bp_no_second_xfer", {31'b0, PSEL}, 32'd0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_rsp(rd, er, tm);
            chk($sformatf("bp%0d_rdata", i), rd, burst[i].exp_rdata);
            chk($sformatf("bp%0d_err", i), {31'b0, er}, {31'b0, burst[i].exp_err});
        end
        repeat (5) @(negedge clk);
        chk("bp_no_extra_rsp", {31'b0, rsp_valid}, 32'd0);

        // Reset pulse during ACCESS discards transfer and queue
        stuck = 1'b1;
        send_cmd(1'b0, 32'h4, 32'h0);
        send_cmd(1'b0, 32'h0, 32'h0);
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge clk); n++;
        end
        chk("mid_access_reached", {31'b0, PENABLE}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_psel", {31'b0, PSEL}, 32'd0);
        chk("mid_rst_penable", {31'b0, PENABLE}, 32'd0);
        chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        stuck = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        psel_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (PSEL || rsp_valid) psel_seen++;
        end
        chk("mid_rst_queue_dropped", psel_seen, 32'd0);
        chk("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        send_cmd(1'b0, 32'h0, 32'h0);
        get_rsp(rd, er, tm);
        chk("after_rst_rdata", rd, 32'h11111111);

`ifdef APB_CMD_TIMEOUT_EN
        // PREADY stuck low: abort after 16 ACCESS cycles
        stuck = 1'b1;
        send_cmd(1'b0, 32'h4, 32'h0);
        n = 0; en_cnt = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk); n++;
            if (PENABLE) en_cnt++;
        end
        chk("tmo_access_cycles", en_cnt, 32'd16);
        stuck = 1'b0;
        get_rsp(rd, er, tm);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_err", {31'b0, er}, 32'd1);
        chk("tmo_flag", {31'b0, tm}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
